// File: rtl/otter_cu_fsm.sv
// OTTER multicycle control-unit sequencer: INIT/FETCH/EXEC/WB(/INTR) with memory stall handling.
// Optional interrupt entry is compiled in when OTTER_CU_INTR_EN is defined.
module otter_cu_fsm #(
  parameter int unsigned INIT_CYCLES = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [6:0]       IR_OPCODE,
  input  logic [2:0]       IR_FUNCT,
  input  logic             MEM_RDY,
  input  logic             INTR,
  output logic             PC_WRITE,
  output logic             RF_WR_EN,
  output logic             MEM_RDEN1,
  output logic             MEM_RDEN2,
  output logic             MEM_WE2,
  output logic             RST_OUT,
  output logic             INT_TAKEN,
  output logic             ILLEGAL,
  output logic [CNT_W-1:0] INSTRET
);

  localparam logic [2:0] StInit  = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StExec  = 3'd2;
  localparam logic [2:0] StWb    = 3'd3;
`ifdef OTTER_CU_INTR_EN
  localparam logic [2:0] StIntr  = 3'd4;
`endif

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam int unsigned InitW = (INIT_CYCLES > 2) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [InitW-1:0] InitLast = InitW'(INIT_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [InitW-1:0] init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;
  logic [2:0]       done_state;

  // Interrupts are only sampled when an instruction completes.
`ifdef OTTER_CU_INTR_EN
  assign done_state = INTR ? StIntr : StFetch;
`else
  logic unused_intr;
  assign unused_intr = INTR;
  assign done_state  = StFetch;
`endif

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    retire     = 1'b0;
    PC_WRITE   = 1'b0;
    RF_WR_EN   = 1'b0;
    MEM_RDEN1  = 1'b0;
    MEM_RDEN2  = 1'b0;
    MEM_WE2    = 1'b0;
    RST_OUT    = 1'b0;
    INT_TAKEN  = 1'b0;
    ILLEGAL    = 1'b0;
    case (state_q)
      StInit: begin
        RST_OUT    = 1'b1;
        init_cnt_d = init_cnt_q + InitW'(1);
        if (init_cnt_q == InitLast) state_d = StFetch;
      end
      StFetch: begin
        MEM_RDEN1 = 1'b1;
        if (MEM_RDY) state_d = StExec;
      end
      StExec: begin
        PC_WRITE = 1'b1;
        case (IR_OPCODE)
          OpLoad:   MEM_RDEN2 = 1'b1;
          OpStore:  MEM_WE2   = 1'b1;
          OpBranch: ;
          OpOp, OpImm, OpLui, OpAuipc, OpJal, OpJalr: RF_WR_EN = 1'b1;
          OpSystem: RF_WR_EN = (IR_FUNCT != 3'b000);
          default:  ILLEGAL  = 1'b1;
        endcase
        if (IR_OPCODE == OpLoad) begin
          state_d = StWb;
        end else begin
          retire  = 1'b1;
          state_d = done_state;
        end
      end
      StWb: begin
        if (MEM_RDY) begin
          RF_WR_EN = 1'b1;
          retire   = 1'b1;
          state_d  = done_state;
        end
      end
`ifdef OTTER_CU_INTR_EN
      StIntr: begin
        INT_TAKEN = 1'b1;
        PC_WRITE  = 1'b1;
        state_d   = StFetch;
      end
`endif
      default: state_d = StInit;
    endcase
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      instret_q  <= instret_d;
    end
  end

  assign INSTRET = instret_q;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Scoreboard bench for otter_cu_fsm: stimulus pushes per-cycle expected outputs, monitor checks.
module tb_otter_cu_fsm;

  localparam logic [7:0] O_RST = 8'h80;
  localparam logic [7:0] O_PC  = 8'h40;
  localparam logic [7:0] O_RF  = 8'h20;
  localparam logic [7:0] O_RD1 = 8'h10;
  localparam logic [7:0] O_RD2 = 8'h08;
  localparam logic [7:0] O_WE2 = 8'h04;
  localparam logic [7:0] O_INT = 8'h02;
  localparam logic [7:0] O_ILL = 8'h01;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] BRCH  = 7'b1100011;
  localparam logic [6:0] ADD   = 7'b0110011;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] SYS   = 7'b1110011;
  localparam logic [6:0] BAD   = 7'b1111111;

  logic        CLK, RST, MEM_RDY, INTR;
  logic [6:0]  IR_OPCODE;
  logic [2:0]  IR_FUNCT;
  logic        PC_WRITE, RF_WR_EN, MEM_RDEN1, MEM_RDEN2, MEM_WE2, RST_OUT, INT_TAKEN, ILLEGAL;
  logic [31:0] INSTRET;

  typedef struct {
    string       tag;
    logic [7:0]  outs;
    logic [31:0] instret;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n = 0;

  otter_cu_fsm #(.INIT_CYCLES(2), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .IR_OPCODE(IR_OPCODE), .IR_FUNCT(IR_FUNCT), .MEM_RDY(MEM_RDY),
    .INTR(INTR), .PC_WRITE(PC_WRITE), .RF_WR_EN(RF_WR_EN), .MEM_RDEN1(MEM_RDEN1),
    .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .RST_OUT(RST_OUT), .INT_TAKEN(INT_TAKEN),
    .ILLEGAL(ILLEGAL), .INSTRET(INSTRET)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one cycle's inputs just after the rising edge and queue that cycle's expectation.
  task automatic step(input string tag, input logic rst, input logic [6:0] op,
                      input logic [2:0] fn, input logic rdy, input logic intr,
                      input logic [7:0] outs, input logic [31:0] ir);
    exp_t e;
    @(posedge CLK);
    #1;
    RST = rst; IR_OPCODE = op; IR_FUNCT = fn; MEM_RDY = rdy; INTR = intr;
    e.tag = tag; e.outs = outs; e.instret = ir;
    sb_q.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e   = sb_q.pop_front();
      act = {RST_OUT, PC_WRITE, RF_WR_EN, MEM_RDEN1, MEM_RDEN2, MEM_WE2, INT_TAKEN, ILLEGAL};
      checks++;
      if (act !== e.outs || INSTRET !== e.instret) begin
        errors++;
        $display("FAIL %s outs=%b required=%b instret=%0d required=%0d",
                 e.tag, act, e.outs, INSTRET, e.instret);
      end
    end
  end

  initial begin
    RST = 1'b1; IR_OPCODE = ADD; IR_FUNCT = 3'b000; MEM_RDY = 1'b1; INTR = 1'b1;
    step("reset_a", 1, ADD, 0, 1, 1, O_RST, 0);
    step("reset_b", 1, ADD, 0, 1, 1, O_RST, 0);
    // INTR high during INIT must be ignored.
    step("init0", 0, ADD, 0, 1, 1, O_RST, 0);
    step("init1", 0, ADD, 0, 1, 1, O_RST, 0);
    step("fetch_first", 0, ADD, 0, 1, 0, O_RD1, 0);
    step("add_exec", 0, ADD, 0, 1, 0, O_PC | O_RF, n); n++;
    step("fetch_stall0", 0, ADD, 0, 0, 1, O_RD1, n);
    step("fetch_stall1", 0, ADD, 0, 0, 1, O_RD1, n);
    step("fetch_go", 0, LUI, 0, 1, 0, O_RD1, n);
    step("lui_exec", 0, LUI, 0, 1, 0, O_PC | O_RF, n); n++;
    step("fetch", 0, LOAD, 0, 1, 0, O_RD1, n);
    step("load_exec", 0, LOAD, 0, 0, 0, O_PC | O_RD2, n);
    for (int i = 0; i < 3; i++) step("wb_stall", 0, LOAD, 0, 0, 1, 8'h00, n);
    step("wb_done", 0, LOAD, 0, 1, 0, O_RF, n); n++;
    step("fetch", 0, BRCH, 0, 1, 0, O_RD1, n);
    step("branch_exec", 0, BRCH, 0, 1, 0, O_PC, n); n++;
    step("fetch", 0, SYS, 3'b000, 1, 0, O_RD1, n);
    step("sys_f0_exec", 0, SYS, 3'b000, 1, 0, O_PC, n); n++;
    step("fetch", 0, SYS, 3'b001, 1, 0, O_RD1, n);
    step("sys_f1_exec", 0, SYS, 3'b001, 1, 0, O_PC | O_RF, n); n++;
    step("fetch", 0, JAL, 0, 1, 0, O_RD1, n);
    step("jal_exec", 0, JAL, 0, 1, 0, O_PC | O_RF, n); n++;
    step("fetch", 0, STORE, 0, 1, 0, O_RD1, n);
    step("store_exec", 0, STORE, 0, 1, 1, O_PC | O_WE2, n); n++;
`ifdef OTTER_CU_INTR_EN
    step("intr_entry", 0, BAD, 0, 1, 0, O_INT | O_PC, n);
`endif
    step("fetch", 0, BAD, 0, 1, 0, O_RD1, n);
    step("illegal_exec", 0, BAD, 0, 1, 0, O_PC | O_ILL, n); n++;
    step("fetch", 0, LOAD, 0, 1, 0, O_RD1, n);
    step("load_exec2", 0, LOAD, 0, 0, 0, O_PC | O_RD2, n);
    step("wb_stall2", 0, LOAD, 0, 0, 0, 8'h00, n);
    step("rst_mid_a", 1, LOAD, 0, 0, 0, O_RST, 0);
    step("rst_mid_b", 1, LOAD, 0, 1, 0, O_RST, 0);
    step("reinit0", 0, ADD, 0, 1, 0, O_RST, 0);
    step("reinit1", 0, ADD, 0, 1, 0, O_RST, 0);
    step("refetch", 0, ADD, 0, 1, 0, O_RD1, 0);
    step("readd_exec", 0, ADD, 0, 1, 0, O_PC | O_RF, 0);
    step("refetch2", 0, ADD, 0, 0, 0, O_RD1, 1);
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge CLK);
    #1;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
